// File: rtl/mfcc_frame_buffer_pkg.sv
// Shared constants, types and slot/position helpers for the MFCC frame buffer.
package mfcc_pkg;

   localparam int DATA_W     = 16;              // signed Q4 coefficient
   localparam int N_DCT      = 32;              // coefficients per frame from the DCT
   localparam int NUM_COEFFS = 13;              // cepstral coefficients kept (must be <= N_DCT)
   localparam int NUM_FRAMES = 49;              // frames per output window
   localparam int DEPTH      = NUM_FRAMES + 1;  // window plus the frame under construction

   localparam int SLOT_W  = $clog2(DEPTH);
   localparam int COEF_W  = $clog2(NUM_COEFFS);
   localparam int NIDX_W  = $clog2(N_DCT);
   localparam int FRAME_W = $clog2(NUM_FRAMES);
   localparam int FCNT_W  = $clog2(NUM_FRAMES + 1);

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } state_t;

   // Position of the next word to fetch during a readout.
   typedef struct packed {
      logic [SLOT_W-1:0]  slot;
      logic [COEF_W-1:0]  coeff;
      logic [FRAME_W-1:0] frame;
   } rd_pos_t;

   // Slot index advance; DEPTH is not a power of two so wrap explicitly.
   function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
      return (s == SLOT_W'(DEPTH - 1)) ? '0 : s + SLOT_W'(1);
   endfunction

   // Frame-major, coefficient-minor walk through the window.
   function automatic rd_pos_t pos_inc(input rd_pos_t p);
      rd_pos_t n;
      n = p;
      if (p.coeff == COEF_W'(NUM_COEFFS - 1)) begin
         n.coeff = '0;
         n.slot  = slot_inc(p.slot);
         n.frame = p.frame + FRAME_W'(1);
      end else begin
         n.coeff = p.coeff + COEF_W'(1);
      end
      return n;
   endfunction

   // True for the final word of the window.
   function automatic logic pos_is_last(input rd_pos_t p);
      return (p.frame == FRAME_W'(NUM_FRAMES - 1)) &&
             (p.coeff == COEF_W'(NUM_COEFFS - 1));
   endfunction

endpackage

// File: rtl/mfcc_frame_buffer_if.sv
// Feature stream from the frame buffer to the classifier.
// Handshake: a word transfers on a rising clk edge where feature_valid and
// feature_ready are both high. Once feature_valid is raised, feature_out,
// feature_valid and feature_last stay unchanged until that transfer happens;
// the producer never waits for feature_ready before raising feature_valid,
// and feature_ready may change in any cycle.
interface mfcc_frame_buffer_if;
   import mfcc_pkg::*;

   logic [DATA_W-1:0] feature_out;
   logic              feature_valid;
   logic              feature_ready;
   logic              feature_last;

   modport master (
      output feature_out,
      output feature_valid,
      output feature_last,
      input  feature_ready
   );

   modport slave (
      input  feature_out,
      input  feature_valid,
      input  feature_last,
      output feature_ready
   );

endinterface

// File: rtl/mfcc_frame_buffer_ram.sv
// Slot/coefficient register array: one synchronous write port and one read
// port whose registered output holds when no read is issued, so it doubles
// as the data half of the output handshake register.
module feature_ram
   import mfcc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [SLOT_W-1:0] wr_slot_i,
   input  logic [COEF_W-1:0] wr_coeff_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              re_i,
   input  logic [SLOT_W-1:0] rd_slot_i,
   input  logic [COEF_W-1:0] rd_coeff_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [DEPTH][NUM_COEFFS];
   logic [DATA_W-1:0] rd_data_q;

   // Store incoming coefficients; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[wr_slot_i][wr_coeff_i] <= wr_data_i;
      end
   end

   // Registered read; holds its value while no new word is requested.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (re_i) begin
         rd_data_q <= mem_q[rd_slot_i][rd_coeff_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mfcc_frame_buffer.sv
// MFCC frame buffer: keeps the first NUM_COEFFS coefficients of each DCT
// frame in a circular store and streams the NUM_FRAMES most recent complete
// frames, oldest first, when a window is requested.
module mfcc_frame_buffer
   import mfcc_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_W-1:0]  dct_in,      // signed Q4, passed through bit-exact
   input  logic               dct_valid,
   input  logic               window_req,
   mfcc_frame_buffer_if.master feat,
   output logic               window_full,
   output logic               busy,
   output logic               overrun,
   output state_t             state_dbg_o
);

   // ---------------------------------------------------------------
   // Write path
   // ---------------------------------------------------------------
   logic [NIDX_W-1:0] coeff_idx_q, coeff_idx_d;
   logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
   logic [FCNT_W-1:0] frame_count_q, frame_count_d;
   logic              window_full_q, window_full_d;
   logic              commit;
   logic              wr_en;

   // Coefficient index, slot advance on frame commit, saturating frame count.
   always_comb begin
      commit        = dct_valid && (coeff_idx_q == NIDX_W'(N_DCT - 1));
      wr_en         = dct_valid &&
                      ({1'b0, coeff_idx_q} < (NIDX_W + 1)'(NUM_COEFFS));
      coeff_idx_d   = coeff_idx_q;
      wr_slot_d     = wr_slot_q;
      frame_count_d = frame_count_q;
      if (dct_valid) begin
         coeff_idx_d = commit ? '0 : coeff_idx_q + NIDX_W'(1);
      end
      if (commit) begin
         wr_slot_d = slot_inc(wr_slot_q);
         if (frame_count_q != FCNT_W'(NUM_FRAMES)) begin
            frame_count_d = frame_count_q + FCNT_W'(1);
         end
      end
      window_full_d = (frame_count_d == FCNT_W'(NUM_FRAMES));
   end

   // Write-path registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         coeff_idx_q   <= '0;
         wr_slot_q     <= '0;
         frame_count_q <= '0;
         window_full_q <= 1'b0;
      end else begin
         coeff_idx_q   <= coeff_idx_d;
         wr_slot_q     <= wr_slot_d;
         frame_count_q <= frame_count_d;
         window_full_q <= window_full_d;
      end
   end

   // ---------------------------------------------------------------
   // Readout FSM
   // ---------------------------------------------------------------
   state_t            state_q, state_d;
   rd_pos_t           pos_q, pos_d, start_pos;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic [1:0]        commit_cnt_q, commit_cnt_d;
   logic              overrun_q, overrun_d;
   logic              rd_en;
   logic [SLOT_W-1:0] rd_slot;
   logic [COEF_W-1:0] rd_coeff;
   logic [DATA_W-1:0] rd_data;
   logic              accept;
   logic              read_done;

   // window_full_q is the registered, pre-commit view, so a frame committing
   // in the request cycle is neither counted nor included in the snapshot.
   assign accept    = (state_q == IDLE) && window_req && window_full_q;
   assign read_done = (state_q == READ) && valid_q && feat.feature_ready && last_q;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = READ;
         READ:    if (read_done) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // Read fetch, output handshake stage and overrun tracking.
   always_comb begin
      start_pos.slot  = slot_inc(wr_slot_q);   // oldest complete frame
      start_pos.coeff = '0;
      start_pos.frame = '0;
      pos_d        = pos_q;
      valid_d      = valid_q;
      last_d       = last_q;
      commit_cnt_d = commit_cnt_q;
      overrun_d    = overrun_q;
      rd_en        = 1'b0;
      rd_slot      = pos_q.slot;
      rd_coeff     = pos_q.coeff;
      case (state_q)
         IDLE: begin
            if (accept) begin
               // First word is fetched in the accept cycle so it is
               // presented on the very next cycle.
               rd_en        = 1'b1;
               rd_slot      = start_pos.slot;
               rd_coeff     = start_pos.coeff;
               pos_d        = pos_inc(start_pos);
               valid_d      = 1'b1;
               last_d       = pos_is_last(start_pos);
               commit_cnt_d = commit ? 2'd1 : 2'd0;
               overrun_d    = 1'b0;
            end
         end
         READ: begin
            if (valid_q && feat.feature_ready) begin
               if (last_q) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  rd_en  = 1'b1;
                  pos_d  = pos_inc(pos_q);
                  last_d = pos_is_last(pos_q);
               end
            end
            // The second commit during a readout lands on the snapshot's
            // oldest slot; flag it but keep streaming.
            if (commit) begin
               if (commit_cnt_q == 2'd1) begin
                  overrun_d = 1'b1;
               end
               if (commit_cnt_q != 2'd2) begin
                  commit_cnt_d = commit_cnt_q + 2'd1;
               end
            end
         end
         default: begin
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
      endcase
   end

   // Readout datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_q        <= '0;
         valid_q      <= 1'b0;
         last_q       <= 1'b0;
         commit_cnt_q <= '0;
         overrun_q    <= 1'b0;
      end else begin
         pos_q        <= pos_d;
         valid_q      <= valid_d;
         last_q       <= last_d;
         commit_cnt_q <= commit_cnt_d;
         overrun_q    <= overrun_d;
      end
   end

   feature_ram u_ram (
      .clk        (clk),
      .rst        (rst),
      .we_i       (wr_en),
      .wr_slot_i  (wr_slot_q),
      .wr_coeff_i (coeff_idx_q[COEF_W-1:0]),
      .wr_data_i  (dct_in),
      .re_i       (rd_en),
      .rd_slot_i  (rd_slot),
      .rd_coeff_i (rd_coeff),
      .rd_data_o  (rd_data)
   );

   assign feat.feature_out   = rd_data;
   assign feat.feature_valid = valid_q;
   assign feat.feature_last  = last_q;
   assign window_full        = window_full_q;
   assign busy               = (state_q == READ);
   assign overrun            = overrun_q;
   assign state_dbg_o        = state_q;

endmodule

// File: tb/tb_mfcc_frame_buffer.sv
// Bench for mfcc_frame_buffer: frame-level reference model (queue of kept
// words per frame, window = most recent 49 frames) and an expected-word queue.
module tb_mfcc_frame_buffer;

   localparam int NC = 13;
   localparam int NF = 49;
   localparam int NW = 32;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] dct_in = '0;
   logic        dct_valid = 1'b0;
   logic        window_req = 1'b0;
   logic        window_full;
   logic        busy;
   logic        overrun;
   mfcc_pkg::state_t state_dbg;

   always #5 clk = ~clk;

   mfcc_frame_buffer_if fif ();

   mfcc_frame_buffer dut (
      .clk         (clk),
      .rst         (rst),
      .dct_in      (dct_in),
      .dct_valid   (dct_valid),
      .window_req  (window_req),
      .feat        (fif),
      .window_full (window_full),
      .busy        (busy),
      .overrun     (overrun),
      .state_dbg_o (state_dbg)
   );

   // ---------------- reference model / scoreboard ----------------
   logic [15:0] win_q[$];   // kept words of the most recent complete frames
   logic [15:0] cur_q[$];   // kept words of the frame being received
   logic [15:0] exp_q[$];   // expected words of the current readout
   int          m_k;
   int          m_commits;
   bit          m_busy;
   bit          m_full;
   bit          m_ovr;
   int          n_hs;
   logic [15:0] first_word;
   logic [15:0] last_word;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      win_q.delete();
      cur_q.delete();
      exp_q.delete();
      m_k = 0;
      m_commits = 0;
      m_busy = 0;
      m_full = 0;
      m_ovr = 0;
      n_hs = 0;
   endtask

   // ---------------- driver tasks ----------------
   // One clock: drive inputs, score a handshake, advance the model, check.
   task automatic cycle(input logic v, input logic [15:0] d, input logic req, input logic rdy);
      logic [15:0] w;
      logic [15:0] hold_out;
      logic        hold_last;
      bit          stall;
      bit          ended;
      bit          acc;
      dct_valid = v;
      dct_in = d;
      window_req = req;
      fif.feature_ready = rdy;
      ended = 0;
      if (m_busy && rdy) begin
         check_eq("hs_valid", 32'(fif.feature_valid), 32'd1);
         w = exp_q.pop_front();
         n_hs++;
         if (n_hs == 1) first_word = fif.feature_out;
         last_word = fif.feature_out;
         if (m_commits == 0) check_eq("word", 32'(fif.feature_out), 32'(w));
         check_eq("last", 32'(fif.feature_last), 32'(exp_q.size() == 0));
         ended = (exp_q.size() == 0);
      end
      stall = fif.feature_valid && !rdy;
      hold_out = fif.feature_out;
      hold_last = fif.feature_last;
      @(posedge clk);
      acc = !m_busy && req && m_full;
      if (acc) begin
         exp_q = win_q;
         m_busy = 1;
         m_ovr = 0;
         m_commits = 0;
         n_hs = 0;
      end
      if (v) begin
         if (m_k < NC) cur_q.push_back(d);
         if (m_k == NW - 1) begin
            foreach (cur_q[i]) win_q.push_back(cur_q[i]);
            cur_q.delete();
            while (win_q.size() > NF * NC) win_q.delete(0);
            if (m_busy) begin
               m_commits++;
               if (m_commits == 2) m_ovr = 1;
            end
         end
         m_k = (m_k + 1) % NW;
      end
      if (ended) m_busy = 0;
      m_full = (win_q.size() == NF * NC);
      #1;
      check_eq("busy", 32'(busy), 32'(m_busy));
      check_eq("valid", 32'(fif.feature_valid), 32'(m_busy));
      check_eq("full", 32'(window_full), 32'(m_full));
      check_eq("overrun", 32'(overrun), 32'(m_ovr));
      if (!m_busy) check_eq("last_idle", 32'(fif.feature_last), 32'd0);
      if (stall) begin
         check_eq("hold_out", 32'(fif.feature_out), 32'(hold_out));
         check_eq("hold_last", 32'(fif.feature_last), 32'(hold_last));
      end
   endtask

   task automatic feed_frame(input int f, input bit rnd, input bit gaps);
      logic [15:0] d;
      for (int k = 0; k < NW; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) cycle(1'b0, 16'h0, 1'b0, 1'b0);
         d = rnd ? 16'($urandom) : 16'(f * 100 + k);
         cycle(1'b1, d, 1'b0, 1'b0);
      end
   endtask

   // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready.
   task automatic run_readout(input int mode, input int stop_after, input bit do_req);
      int   budget;
      int   ph;
      logic rdy;
      ph = 0;
      budget = 0;
      if (do_req) cycle(1'b0, 16'h0, 1'b1, 1'b0);
      while (m_busy && budget < 5000 && !(stop_after > 0 && n_hs >= stop_after)) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ((ph % 4) == 0) || ((ph % 4) == 3);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         ph++;
         cycle(1'b0, 16'h0, 1'b0, rdy);
         budget++;
      end
      check_eq("rd_budget", 32'(budget < 5000), 32'd1);
   endtask

   // Asynchronous reset asserted between clock edges; outputs checked
   // before any further edge.
   task automatic do_reset();
      #2;
      rst = 1'b1;
      dct_valid = 1'b0;
      window_req = 1'b0;
      fif.feature_ready = 1'b0;
      #1;
      check_eq("rst_out", 32'(fif.feature_out), 32'd0);
      check_eq("rst_valid", 32'(fif.feature_valid), 32'd0);
      check_eq("rst_last", 32'(fif.feature_last), 32'd0);
      check_eq("rst_full", 32'(window_full), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_ovr", 32'(overrun), 32'd0);
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      fif.feature_ready = 1'b0;
      model_clear();
      #1;
      do_reset();

      // Single frame: window never fills, request ignored.
      feed_frame(0, 1'b0, 1'b0);
      check_eq("single_full", 32'(window_full), 32'd0);
      cycle(1'b0, 16'h0, 1'b1, 1'b1);
      repeat (3) cycle(1'b0, 16'h0, 1'b0, 1'b1);
      check_eq("single_ignored", 32'(busy), 32'd0);

      // Fill 49 frames of f*100+k, then a full-speed readout.
      do_reset();
      for (int f = 0; f < NF; f++) begin
         feed_frame(f, 1'b0, 1'b1);
         if (f == NF - 2) check_eq("full_after_47", 32'(window_full), 32'd0);
         if (f == NF - 1) check_eq("full_after_48", 32'(window_full), 32'd1);
      end
      run_readout(0, 0, 1'b1);
      check_eq("fill_count", 32'(n_hs), 32'd637);
      check_eq("fill_first", 32'(first_word), 32'd0);
      check_eq("fill_last", 32'(last_word), 32'd4812);
      check_eq("fill_busy_end", 32'(busy), 32'd0);

      // Sliding window after 52 frames.
      for (int f = NF; f < 52; f++) feed_frame(f, 1'b0, 1'b0);
      run_readout(0, 0, 1'b1);
      check_eq("slide_count", 32'(n_hs), 32'd637);
      check_eq("slide_first", 32'(first_word), 32'd300);
      check_eq("slide_last", 32'(last_word), 32'd5112);

      // Backpressure with ready pattern 1,0,0,1.
      run_readout(1, 0, 1'b1);
      check_eq("bp_count", 32'(n_hs), 32'd637);
      check_eq("bp_first", 32'(first_word), 32'd300);
      check_eq("bp_last", 32'(last_word), 32'd5112);

      // Overrun: two commits while the consumer stalls.
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      feed_frame(52, 1'b0, 1'b0);
      check_eq("ovr_first_commit", 32'(overrun), 32'd0);
      feed_frame(53, 1'b0, 1'b0);
      check_eq("ovr_second_commit", 32'(overrun), 32'd1);
      run_readout(0, 0, 1'b0);
      check_eq("ovr_count", 32'(n_hs), 32'd637);
      check_eq("ovr_hold", 32'(overrun), 32'd1);
      run_readout(0, 0, 1'b1);
      check_eq("ovr_cleared", 32'(overrun), 32'd0);
      check_eq("ovr_next_first", 32'(first_word), 32'd500);
      check_eq("ovr_next_last", 32'(last_word), 32'd5312);

      // Reset in the middle of a readout.
      run_readout(0, 100, 1'b1);
      check_eq("mid_busy", 32'(busy), 32'd1);
      do_reset();
      for (int f = 0; f < 5; f++) feed_frame(f, 1'b1, 1'b1);
      cycle(1'b0, 16'h0, 1'b1, 1'b1);
      repeat (3) cycle(1'b0, 16'h0, 1'b0, 1'b1);
      check_eq("post_rst_ignored", 32'(busy), 32'd0);

      // Random data refill and randomly stalled readout.
      for (int f = 0; f < NF; f++) feed_frame(f, 1'b1, 1'b1);
      run_readout(2, 0, 1'b1);
      check_eq("rand_count", 32'(n_hs), 32'd637);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard stop if the stimulus ever stalls.
   initial begin
      #2000000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
